lcd_bus_receiver: RTL and testbench
===================================

# lcd_bus_receiver

Display-side endpoint of the 8-bit 8080-style write bus (`wr`, `dcx`, `D`) driven by the image generator. It captures each byte on the rising edge of `wr` and decodes the ILI9341-subset command stream: CASET, PASET, RAMWR, SWRESET, SLPOUT, DISPON. It maintains the column/page address window and emits one RGB565 pixel write (x, y, colour) per two RAMWR data bytes. It serves as the display model in simulation and as the front end of an on-chip framebuffer.

## Interface
- `WIDTH`, default 240: column count; valid columns 0..WIDTH-1.
- `HEIGHT`, default 320: page count; valid pages 0..HEIGHT-1.

- `clk`  in  1  system clock; the same clock that generates `wr`.
- `rst`  in  1  synchronous, active-high reset.
- `wr`  in  1  write strobe; a byte is taken on a 0→1 transition.
- `dcx`  in  1  0 = command byte, 1 = data/parameter byte.
- `D`  in  8  bus byte.
- `cmd_valid`  out  1  one-cycle pulse per accepted command byte.
- `cmd_code`  out  8  last command byte; valid with `cmd_valid`, held afterwards.
- `pix_valid`  out  1  one-cycle pulse per completed pixel.
- `pix_x`  out  16  pixel column; valid with `pix_valid`.
- `pix_y`  out  16  pixel page; valid with `pix_valid`.
- `pix_color`  out  16  RGB565 value, {high byte, low byte}.
- `disp_on`  out  1  set by DISPON (0x29).
- `sleep_out`  out  1  set by SLPOUT (0x11).
- `err`  out  1  one-cycle pulse on an invalid window or an aborted parameter sequence.

## Operation
- **Strobe detection**
  - `wr_q` holds the registered copy of `wr` and resets to 1, so `wr` held high out of reset does not produce a strobe.
  - The strobe cycle is any cycle with `wr`=1 and `wr_q`=0. `D` and `dcx` are sampled in that cycle only.
- **Command byte (`dcx`=0)**
  - Always accepted in any state; pulses `cmd_valid` and loads `cmd_code`.
  - If a CASET or PASET parameter sequence is incomplete (1–3 of 4 bytes received), it is discarded: window unchanged, `err` pulses.
  - Next state by code:
    - 0x2A → CASET_P, parameter index 0.
    - 0x2B → PASET_P, parameter index 0.
    - 0x2C → RAM_HI; the address counters load (SC, SP).
    - 0x01 → IDLE; window returns to defaults; `disp_on`=0 and `sleep_out`=0.
    - 0x11 → IDLE; `sleep_out`=1.
    - 0x29 → IDLE; `disp_on`=1.
    - Any other code → IDLE, no further effect.
- **Data byte (`dcx`=1)**
  - IDLE: the byte is ignored.
  - CASET_P / PASET_P: parameters arrive in order start[15:8], start[7:0], end[15:8], end[7:0] and go into shadow registers.
    - On the 4th byte, the window is committed if start ≤ end and end ≤ limit-1 (limit = WIDTH for CASET, HEIGHT for PASET).
    - Otherwise the window is unchanged and `err` pulses.
    - Either way the state returns to IDLE.
  - RAM_HI: latch the high byte → RAM_LO.
  - RAM_LO: emit a pixel at the current (col, page) → RAM_HI, then advance the address:
    - if col < EC: col+1;
    - else col=SC and page+1, or page=SP if page=EP (the whole window wraps).
- A high byte left pending when a command arrives is silently discarded.
- **State machine:** IDLE, CASET_P, PASET_P, RAM_HI, RAM_LO. A parameter index 0..3 is shared by CASET_P and PASET_P.
- **Widths:** SC, EC, SP, EP and the counters are 16-bit and unsigned.
- **Default window:** SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1.

## Timing
- All outputs are registered.
- `cmd_valid`, `pix_valid` and `err` assert in the cycle after the strobe cycle, for exactly one cycle.
- Back-to-back strobes are allowed with a minimum `wr` period of 2 clocks (low 1, high 1). The receiver accepts one byte per strobe with no backpressure.
- A committed CASET/PASET takes effect for a RAMWR command strobed on the very next `wr` edge.
- When `rst`=1 at an edge, the following hold at the next cycle:
  - state = IDLE, window = defaults, counters = 0, `wr_q`=1;
  - all pulses are 0, `cmd_code`=0x00, `pix_x`/`pix_y`/`pix_color`=0, `disp_on`=0, `sleep_out`=0.
- Reset during RAMWR or a parameter sequence drops the partial byte or sequence with no `err`.
- A strobe coincident with `rst` is ignored.

## Test plan
- **Default window:** reset, then 0x2C and data F8 00 07 E0 → two `pix_valid` pulses: (0,0,F800), then (1,0,07E0).
- **Programmed window with wrap:** CASET 00 0A 00 0B, PASET 00 14 00 15, RAMWR with 5 pixels (10 bytes) → addresses (10,20), (11,20), (10,21), (11,21), (10,20).
- **Invalid window:** CASET 00 05 00 02 → `err` pulses; a following RAMWR pixel lands at (0,0). Separately, CASET 00 00 00 F0 with WIDTH=240 → `err`.
- **Aborted sequence:** 0x2A, 00, 0A, then 0x2C → `err` pulse and `cmd_valid` with 0x2C; the first pixel lands at (0,0). Also: odd byte F8 then 0x29 → no `pix_valid`, `disp_on`=1.
- **Flags:** 0x11 then 0x29 → `sleep_out`=1 and `disp_on`=1. Then 0x01 → both 0 and window = defaults. A stray data byte in IDLE produces no pulses.
- **Reset mid-operation:** assert `rst` after a RAMWR high byte, with `wr` held high through reset → no pulses and all outputs at reset values. The next 0x2C, AA, BB → (0,0,AABB).

Source files
------------

// File: rtl/lcd_bus_if.sv
// 8080-style display write bus: strobe, data/command select and byte.
// The image generator drives it; the display receiver listens.
interface lcd_bus_if;
  logic       wr;
  logic       dcx;
  logic [7:0] D;

  modport master (output wr, dcx, D);
  modport slave  (input  wr, dcx, D);
endinterface

// File: rtl/lcd_bus_receiver.sv
// ILI9341-subset display endpoint: captures bus bytes on wr rising edges,
// tracks the address window and emits one RGB565 pixel per two RAMWR bytes.
module lcd_bus_receiver #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic        clk,
  input  logic        rst,
  lcd_bus_if.slave    bus,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_color,
  output logic        disp_on,
  output logic        sleep_out,
  output logic        err
);

  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPON  = 8'h29;

  localparam logic [15:0] EC_DEF = 16'(WIDTH - 1);
  localparam logic [15:0] EP_DEF = 16'(HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE, CASET_P, PASET_P, RAM_HI, RAM_LO
  } state_t;

  state_t      state, state_n;
  logic [1:0]  pidx, pidx_n;
  logic [15:0] sh_s, sh_s_n, sh_e, sh_e_n;
  logic [15:0] sc, sc_n, ec, ec_n, sp, sp_n, ep, ep_n;
  logic [15:0] col, col_n, page, page_n;
  logic [7:0]  hi, hi_n;
  logic        wr_q;

  logic        cmd_valid_n, pix_valid_n, err_n;
  logic        disp_on_n, sleep_out_n;
  logic [7:0]  cmd_code_n;
  logic [15:0] pix_x_n, pix_y_n, pix_color_n;

  logic        strobe;
  logic        in_param;
  logic [15:0] e_fin, lim_m1;
  logic        win_ok;

  assign strobe   = bus.wr & ~wr_q;
  assign in_param = (state == CASET_P) || (state == PASET_P);
  assign e_fin    = {sh_e[15:8], bus.D};
  assign lim_m1   = (state == CASET_P) ? EC_DEF : EP_DEF;
  assign win_ok   = (sh_s <= e_fin) && (e_fin <= lim_m1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pidx      <= 2'd0;
      sh_s      <= '0;
      sh_e      <= '0;
      sc        <= '0;
      ec        <= EC_DEF;
      sp        <= '0;
      ep        <= EP_DEF;
      col       <= '0;
      page      <= '0;
      hi        <= '0;
      wr_q      <= 1'b1;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
      disp_on   <= 1'b0;
      sleep_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      pidx      <= pidx_n;
      sh_s      <= sh_s_n;
      sh_e      <= sh_e_n;
      sc        <= sc_n;
      ec        <= ec_n;
      sp        <= sp_n;
      ep        <= ep_n;
      col       <= col_n;
      page      <= page_n;
      hi        <= hi_n;
      wr_q      <= bus.wr;
      cmd_valid <= cmd_valid_n;
      cmd_code  <= cmd_code_n;
      pix_valid <= pix_valid_n;
      pix_x     <= pix_x_n;
      pix_y     <= pix_y_n;
      pix_color <= pix_color_n;
      disp_on   <= disp_on_n;
      sleep_out <= sleep_out_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    pidx_n      = pidx;
    sh_s_n      = sh_s;
    sh_e_n      = sh_e;
    sc_n        = sc;
    ec_n        = ec;
    sp_n        = sp;
    ep_n        = ep;
    col_n       = col;
    page_n      = page;
    hi_n        = hi;
    cmd_valid_n = 1'b0;
    cmd_code_n  = cmd_code;
    pix_valid_n = 1'b0;
    pix_x_n     = pix_x;
    pix_y_n     = pix_y;
    pix_color_n = pix_color;
    disp_on_n   = disp_on;
    sleep_out_n = sleep_out;
    err_n       = 1'b0;

    if (strobe && !bus.dcx) begin
      cmd_valid_n = 1'b1;
      cmd_code_n  = bus.D;
      // A partly received window is dropped, never half-applied
      err_n       = in_param && (pidx != 2'd0);
      pidx_n      = 2'd0;
      state_n     = IDLE;
      unique case (bus.D)
        CMD_CASET: state_n = CASET_P;
        CMD_PASET: state_n = PASET_P;
        CMD_RAMWR: begin
          state_n = RAM_HI;
          col_n   = sc;
          page_n  = sp;
        end
        CMD_SWRESET: begin
          sc_n        = '0;
          ec_n        = EC_DEF;
          sp_n        = '0;
          ep_n        = EP_DEF;
          disp_on_n   = 1'b0;
          sleep_out_n = 1'b0;
        end
        CMD_SLPOUT: sleep_out_n = 1'b1;
        CMD_DISPON: disp_on_n   = 1'b1;
        default: ;
      endcase
    end else if (strobe) begin
      unique case (state)
        CASET_P, PASET_P: begin
          pidx_n = pidx + 2'd1;
          unique case (pidx)
            2'd0: sh_s_n[15:8] = bus.D;
            2'd1: sh_s_n[7:0]  = bus.D;
            2'd2: sh_e_n[15:8] = bus.D;
            default: begin
              sh_e_n[7:0] = bus.D;
              state_n     = IDLE;
              if (!win_ok) begin
                err_n = 1'b1;
              end else if (state == CASET_P) begin
                sc_n = sh_s;
                ec_n = e_fin;
              end else begin
                sp_n = sh_s;
                ep_n = e_fin;
              end
            end
          endcase
        end
        RAM_HI: begin
          hi_n    = bus.D;
          state_n = RAM_LO;
        end
        RAM_LO: begin
          pix_valid_n = 1'b1;
          pix_x_n     = col;
          pix_y_n     = page;
          pix_color_n = {hi, bus.D};
          state_n     = RAM_HI;
          // Raster order inside the window; the whole window wraps
          if (col < ec) begin
            col_n = col + 16'd1;
          end else begin
            col_n  = sc;
            page_n = (page == ep) ? sp : page + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Randomized bench for lcd_bus_receiver against a queue-based
// reference model of the command stream and pixel raster.
module tb_lcd_bus_receiver;

  localparam int W = 240;
  localparam int H = 320;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, pix_valid, err, disp_on, sleep_out;
  logic [7:0]  cmd_code;
  logic [15:0] pix_x, pix_y, pix_color;

  lcd_bus_if bus ();

  lcd_bus_receiver #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .disp_on   (disp_on),
    .sleep_out (sleep_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: 0 idle, 1 caset, 2 paset, 3 ramwr
  int         m_mode;
  logic [7:0] m_pq[$];
  int         m_sc, m_ec, m_sp, m_ep;
  int         m_n;
  bit         m_pend;
  logic [7:0] m_hi;
  logic [7:0] m_code;
  bit         m_disp, m_sleep;
  bit         e_cmd, e_pix, e_err;
  int         e_x, e_y;
  logic [15:0] e_c;

  task automatic model_reset();
    m_mode = 0;
    m_pq.delete();
    m_sc = 0; m_ec = W - 1;
    m_sp = 0; m_ep = H - 1;
    m_n = 0;
    m_pend = 0;
    m_code = 8'h00;
    m_disp = 0; m_sleep = 0;
  endtask

  task automatic model_byte(input logic dc, input logic [7:0] d);
    int s, e, w, h;
    e_cmd = 0; e_pix = 0; e_err = 0;
    if (!dc) begin
      e_cmd  = 1;
      m_code = d;
      if ((m_mode == 1 || m_mode == 2) && m_pq.size() > 0) e_err = 1;
      m_pq.delete();
      m_pend = 0;
      m_mode = 0;
      case (d)
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: begin m_mode = 3; m_n = 0; end
        8'h01: begin
          m_sc = 0; m_ec = W - 1; m_sp = 0; m_ep = H - 1;
          m_disp = 0; m_sleep = 0;
        end
        8'h11: m_sleep = 1;
        8'h29: m_disp = 1;
        default: ;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_pq.push_back(d);
      if (m_pq.size() == 4) begin
        s = {m_pq[0], m_pq[1]};
        e = {m_pq[2], m_pq[3]};
        if (s <= e && e <= ((m_mode == 1) ? W : H) - 1) begin
          if (m_mode == 1) begin m_sc = s; m_ec = e; end
          else begin m_sp = s; m_ep = e; end
        end else begin
          e_err = 1;
        end
        m_pq.delete();
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (!m_pend) begin
        m_pend = 1;
        m_hi = d;
      end else begin
        m_pend = 0;
        w = m_ec - m_sc + 1;
        h = m_ep - m_sp + 1;
        e_pix = 1;
        e_x = m_sc + m_n % w;
        e_y = m_sp + (m_n / w) % h;
        e_c = {m_hi, d};
        m_n++;
      end
    end
  endtask

  task automatic send(input logic dc, input logic [7:0] d);
    @(negedge clk);
    chk("quiet", {29'd0, cmd_valid, pix_valid, err}, 32'd0);
    bus.wr = 1'b0;
    @(negedge clk);
    bus.wr  = 1'b1;
    bus.dcx = dc;
    bus.D   = d;
    model_byte(dc, d);
    @(negedge clk);
    chk("cmd_valid", 32'(cmd_valid), 32'(e_cmd));
    chk("pix_valid", 32'(pix_valid), 32'(e_pix));
    chk("err", 32'(err), 32'(e_err));
    chk("cmd_code", 32'(cmd_code), 32'(m_code));
    chk("disp_on", 32'(disp_on), 32'(m_disp));
    chk("sleep_out", 32'(sleep_out), 32'(m_sleep));
    if (e_pix) begin
      chk("pix_x", 32'(pix_x), 32'(e_x));
      chk("pix_y", 32'(pix_y), 32'(e_y));
      chk("pix_color", 32'(pix_color), 32'(e_c));
    end
  endtask

  task automatic cmd(input logic [7:0] d);
    send(1'b0, d);
  endtask

  task automatic dat(input logic [7:0] d);
    send(1'b1, d);
  endtask

  task automatic win(input logic [7:0] c, input int s, input int e);
    cmd(c);
    dat(8'(s >> 8)); dat(8'(s));
    dat(8'(e >> 8)); dat(8'(e));
  endtask

  // wr stays high across reset; an edge made entirely under reset is dropped
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.wr = 1'b0;
    @(negedge clk);
    bus.wr = 1'b1; bus.dcx = 1'b0; bus.D = 8'h29;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_pulses", {29'd0, cmd_valid, pix_valid, err}, 32'd0);
    chk("rst_code", 32'(cmd_code), 32'd0);
    chk("rst_pix", {pix_x, pix_y}, 32'd0);
    chk("rst_color", 32'(pix_color), 32'd0);
    chk("rst_flags", {30'd0, disp_on, sleep_out}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.wr = 1'b1; bus.dcx = 1'b0; bus.D = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    do_reset();

    cmd(8'h2C);
    dat(8'hF8); dat(8'h00); dat(8'h07); dat(8'hE0);

    win(8'h2A, 10, 11);
    win(8'h2B, 20, 21);
    cmd(8'h2C);
    for (int i = 0; i < 10; i++) dat(8'($urandom));

    cmd(8'h01);
    win(8'h2A, 5, 2);
    cmd(8'h2C); dat(8'h12); dat(8'h34);
    win(8'h2A, 0, 240);
    win(8'h2B, 0, 320);
    win(8'h2A, 0, 239);

    cmd(8'h2A); dat(8'h00); dat(8'h0A);
    cmd(8'h2C); dat(8'h55); dat(8'h66);
    dat(8'hF8); cmd(8'h29);

    cmd(8'h11); cmd(8'h29);
    cmd(8'h01);
    dat(8'h77);

    cmd(8'h2C); dat(8'hAA);
    do_reset();
    cmd(8'h2C); dat(8'hAA); dat(8'hBB);

    for (int k = 0; k < 300; k++) begin
      int op, s, e, cnt;
      op = $urandom_range(0, 12);
      case (op)
        0, 1: begin
          s = $urandom_range(0, 250);
          e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 259)
                                          : s + $urandom_range(0, 4);
          win(8'h2A, s, e);
        end
        2, 3: begin
          s = $urandom_range(0, 330);
          e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 339)
                                          : s + $urandom_range(0, 4);
          win(8'h2B, s, e);
        end
        4, 5, 6, 7: begin
          cmd(8'h2C);
          cnt = $urandom_range(0, 14);
          for (int i = 0; i < cnt; i++) dat(8'($urandom));
        end
        8: begin
          case ($urandom_range(0, 3))
            0: cmd(8'h11);
            1: cmd(8'h29);
            2: cmd(8'h01);
            default: cmd(8'($urandom));
          endcase
        end
        9: dat(8'($urandom));
        10, 11: begin
          cmd(($urandom_range(0, 1) == 0) ? 8'h2A : 8'h2B);
          cnt = $urandom_range(1, 3);
          for (int i = 0; i < cnt; i++) dat(8'($urandom_range(0, 1)));
        end
        default: begin
          if ($urandom_range(0, 3) == 0) do_reset();
          else cmd(8'h2C);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
